jtframe_rom_nslots: RTL
=======================

Name: jtframe_rom_nslots

Overview:
- Generalised read-only SDRAM front-end with SLOTS request slots (1..8) sharing one SDRAM controller port.
- Each slot has a one-entry address/data cache, so a repeated address answers with no SDRAM access.
- Arbitration is fixed-priority or round-robin, chosen by parameter.
- 16- or 32-bit slot data; 32-bit reads are assembled from two 16-bit beats.
- Sits between game ROM consumers (CPU, tile and object fetchers) and the SDRAM controller bank port.

Parameters:
SLOTS, 3, number of slots, 1..8
SDRAMW, 22, SDRAM word-address width
AW, 16, slot address width (all slots)
DW, 16, slot data width, 16 or 32 (all slots)
RR, 0, 0 = fixed priority (slot 0 highest); 1 = round-robin
OFFSETS, 0, SLOTS*SDRAMW packed per-slot SDRAM base offsets; slot i at bits [i*SDRAMW +: SDRAMW]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
slot_addr  in  SLOTS*AW  packed slot addresses, in units of DW
slot_cs  in  SLOTS  slot read request, level
slot_clr  in  SLOTS  invalidate the slot cache
slot_dout  out  SLOTS*DW  packed slot data
slot_ok  out  SLOTS  slot data valid for the current slot_addr
sdram_req  out  1  request to controller
sdram_addr  out  SDRAMW  SDRAM word address
sdram_ack  in  1  controller accepted the request
data_dst  in  1  data start strobe (informational, unused for capture)
data_rdy  in  1  16-bit data beat valid
data_read  in  16  SDRAM data

Behaviour:
- Reset (asynchronous, active-high): sdram_req=0, sdram_addr=0, slot_dout=0, cache valid=0 for all slots, rr pointer=0, state=IDLE. slot_ok is therefore 0.
- Address mapping: sdram_addr = OFFSETS[i] + zero-extended addr when DW=16, or + {addr,1'b0} when DW=32. Sum is modulo 2^SDRAMW.
- Hit: slot_ok[i] = cs[i] & valid[i] & (addr[i]==tag[i]). Combinational from registered state, so a hit answers in the same cycle. slot_dout holds the cached data at all times.
- Miss/pending: cs[i] & ~hit[i] & ~(busy with slot i).
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE: if any slot is pending, grant one, latch its addr as tag_req, drive sdram_addr, set sdram_req=1 and go to REQ. With RR=0 the lowest pending index wins. With RR=1 the search starts at the slot after the last grant and wraps at SLOTS-1 to 0.
  - REQ: sdram_req stays high until sdram_ack, which clears it the same cycle and moves to WAIT. A data_rdy in the ack cycle counts as a beat.
  - WAIT: each data_rdy stores one beat. DW=16 needs 1 beat. DW=32 needs 2 beats: low word first, then high word. After the last beat go to FILL.
  - FILL (1 cycle): write data, tag=tag_req, valid=1 into the granted slot, update the rr pointer, return to IDLE. The earliest next grant is the following cycle.
- Miss-to-ok latency, best case: ack latency + beats + 2 cycles.
- Slot addr changes or cs drops mid-fetch: the fetch completes and fills with the requested tag; the slot then misses again if the address differs.
- slot_clr[i] clears valid[i] on the next edge. If it coincides with FILL for slot i, clr wins (valid=0).
- data_rdy in IDLE or REQ before ack (except in the ack cycle): ignored.
- Only one transaction is outstanding at any time.

Optional Feature:
- JTFRAME_ROMSLOTS_TIMEOUT_EN defined: an 8-bit counter runs in REQ/WAIT and resets on each ack or beat.
  - On reaching 255 it drops sdram_req and returns to IDLE with no cache write.
  - The slot stays pending, so it is re-requested.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- SLOTS=3, DW=16, RR=0, OFFSETS slot1=0x1000: cs1 with addr 0x0020, ack after 2 cycles, data_rdy with 0xBEEF -> sdram_addr=0x001020; slot_ok[1]=1 and dout1=0xBEEF 2 cycles after the beat; a repeat read gives ok in the same cycle with no sdram_req.
- RR=0: cs0, cs1 and cs2 all miss simultaneously -> grants in order 0,1,2. RR=1 with slot 0 re-missing each time -> grants 0,1,2,0 with no starvation of slot 2.
- DW=32, addr 0x10, offset 0: beats 0x1111 then 0x2222 -> sdram_addr=0x20, dout=0x22221111.
- During WAIT for slot 0, change slot_addr0 from 5 to 6 -> the fill stores tag 5 (ok stays 0), then a new request goes out for 6.
- slot_clr[2] asserted in the FILL cycle of slot 2 -> valid stays 0 and the slot re-requests. Asserting rst in WAIT -> sdram_req=0, all ok=0 immediately.
- TIMEOUT_EN: withhold ack for 255 cycles -> sdram_req drops, FSM returns to IDLE, then re-requests the same address.

Source files
------------

// File: rtl/jtframe_rom_nslots.sv
// Read-only SDRAM front end: SLOTS one-entry caches share one SDRAM port; JTFRAME_ROMSLOTS_TIMEOUT_EN adds a 255-cycle abort.
// Latency: hit same cycle, miss = ack latency + beats + 2; sdram_req is held until sdram_ack, one transaction in flight.
module jtframe_rom_nslots #(
    parameter int SLOTS  = 3,
    parameter int SDRAMW = 22,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RR     = 0,
    parameter logic [SLOTS*SDRAMW-1:0] OFFSETS = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS-1:0]    slot_clr,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    output logic                sdram_req,
    output logic [SDRAMW-1:0]   sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     gnt, rr_ptr, sel;
    logic              found;
    logic [AW-1:0]     tag_req;
    logic [AW-1:0]     tag  [SLOTS];
    logic [DW-1:0]     data [SLOTS];
    logic [SLOTS-1:0]  valid, hit, pend, fill_mask;
    logic [31:0]       beat_buf;
    logic              beat_cnt, beat, last_beat, timeout;
    logic [AW-1:0]     sel_addr;
    logic [SDRAMW-1:0] sel_off, sel_ext;
    logic              unused;

    assign unused = ^{data_dst, beat_buf};

    always_comb begin
        hit  = '0;
        pend = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]  = slot_cs[i] & valid[i] & (slot_addr[i*AW +: AW] == tag[i]);
            pend[i] = slot_cs[i] & ~hit[i] & ~(state != IDLE && int'(gnt) == i);
        end
    end

    assign slot_ok = hit;

    generate
        for (genvar g = 0; g < SLOTS; g++) begin : g_dout
            assign slot_dout[g*DW +: DW] = data[g];
        end
    endgenerate

    // Round-robin search starts at rr_ptr, which points one past the last grant.
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < SLOTS; k++) begin
            j = ((RR != 0) ? int'(rr_ptr) : 0) + k;
            if (j >= SLOTS) j = j - SLOTS;
            if (!found && pend[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    assign sel_addr  = slot_addr[int'(sel)*AW +: AW];
    assign sel_off   = OFFSETS[int'(sel)*SDRAMW +: SDRAMW];
    assign sel_ext   = (DW == 32) ? SDRAMW'({sel_addr, 1'b0}) : SDRAMW'(sel_addr);
    assign last_beat = (DW != 32) || beat_cnt;
    assign fill_mask = (state == FILL) ? (SLOTS'(1) << gnt) : '0;

`ifdef JTFRAME_ROMSLOTS_TIMEOUT_EN
    logic [7:0] tmo;

    assign timeout = (tmo == 8'hff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo <= '0;
        end else if ((state != REQ && state != WAIT) || (state == REQ && sdram_ack) || beat || timeout) begin
            tmo <= '0;
        end else begin
            tmo <= tmo + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        beat      = 1'b0;
        case (state)
            IDLE: if (found) state_nxt = REQ;
            REQ: begin
                if (sdram_ack) begin
                    beat      = data_rdy;
                    state_nxt = (data_rdy && last_beat) ? FILL : WAIT;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (data_rdy) begin
                    beat = 1'b1;
                    if (last_beat) state_nxt = FILL;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            tag_req    <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            beat_buf   <= '0;
            beat_cnt   <= 1'b0;
            valid      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt        <= sel;
                        tag_req    <= sel_addr;
                        sdram_addr <= sel_off + sel_ext;
                        sdram_req  <= 1'b1;
                        beat_cnt   <= 1'b0;
                    end
                end
                REQ: if (sdram_ack || timeout) sdram_req <= 1'b0;
                FILL: begin
                    data[gnt] <= beat_buf[31 -: DW];
                    tag[gnt]  <= tag_req;
                    rr_ptr    <= (int'(gnt) == SLOTS - 1) ? '0 : gnt + 1'b1;
                end
                default: ;
            endcase
            // Beats shift in from the top so the first (low) word ends up below the second.
            if (beat) begin
                beat_buf <= {data_read, beat_buf[31:16]};
                beat_cnt <= 1'b1;
            end
            valid <= (valid | fill_mask) & ~slot_clr;
        end
    end
endmodule
